// File: rtl/ex_stage.sv
// Execute stage: registered operands feeding an inline RV64IM ALU, multi-cycle M-op sequencing.
// Optional feature: define EX_FWD_EN for operand bypass from the held output result.
module ex_stage #(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_rs1_val,
    input  logic [63:0] in_rs2_val,
    input  logic [63:0] in_imm,
    input  logic [63:0] in_pc,
    input  logic        in_use_imm,
    input  logic        in_use_pc,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam bit         MultiCycle = MULDIV_LAT > 1;
    localparam logic [3:0] BusyInit   = MultiCycle ? 4'(MULDIV_LAT - 2) : 4'd0;
    localparam logic [63:0] MinNeg    = 64'h8000_0000_0000_0000;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] op1_q, op2_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [4:0]  rd_q;
    logic [63:0] res_q;
    logic        res_sel_q;

    logic        accept;
    logic        capture;
    logic        in_is_m;
    logic [63:0] rs1_fwd, rs2_fwd;
    logic [63:0] op1_sel, op2_sel;
    logic [63:0] alu_out;

    assign in_ready = !flush && (state_q == StIdle || (state_q == StDone && out_ready));
    assign accept   = in_valid && in_ready;
    assign in_is_m  = in_funct7 == 7'b0000001;

    assign out_valid  = state_q == StDone;
    // Single-cycle results come straight from the ALU on the held operands; multi-cycle
    // results are captured when the latency counter expires.
    assign out_result = res_sel_q ? res_q : alu_out;
    assign out_rd     = rd_q;

    // ---------------------------------------------------------------------------------------
    // Operand selection
    // ---------------------------------------------------------------------------------------
`ifdef EX_FWD_EN
    always_comb begin
        rs1_fwd = in_rs1_val;
        rs2_fwd = in_rs2_val;
        if (out_valid && out_rd != 5'd0 && out_rd == in_rs1) rs1_fwd = out_result;
        if (out_valid && out_rd != 5'd0 && out_rd == in_rs2) rs2_fwd = out_result;
    end
`else
    logic unused_src_idx;
    assign unused_src_idx = ^{in_rs1, in_rs2};
    assign rs1_fwd = in_rs1_val;
    assign rs2_fwd = in_rs2_val;
`endif

    assign op1_sel = in_use_pc  ? in_pc  : rs1_fwd;
    assign op2_sel = in_use_imm ? in_imm : rs2_fwd;

    // ---------------------------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: state_d = StIdle;
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            if (in_is_m && MultiCycle) begin
                state_d = StBusy;
                cnt_d   = BusyInit;
            end else begin
                state_d = StDone;
            end
        end
        if (flush) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            op1_q     <= 64'd0;
            op2_q     <= 64'd0;
            funct3_q  <= 3'd0;
            funct7_q  <= 7'd0;
            rd_q      <= 5'd0;
            res_q     <= 64'd0;
            res_sel_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op1_q     <= op1_sel;
                op2_q     <= op2_sel;
                funct3_q  <= in_funct3;
                funct7_q  <= in_funct7;
                rd_q      <= in_rd;
                res_sel_q <= 1'b0;
            end
            if (capture) begin
                res_q     <= alu_out;
                res_sel_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // ALU (RV64I register ops + M extension), fed only from the operand registers
    // ---------------------------------------------------------------------------------------
    logic         mul_sa, mul_sb;
    logic [127:0] prod;
    logic         div_zero, div_ovf;
    logic [63:0]  udiv_b, sdiv_b;
    logic [63:0]  udiv, urem, sdiv, srem;

    assign mul_sa = funct3_q == 3'b001 || funct3_q == 3'b010;
    assign mul_sb = funct3_q == 3'b001;
    assign prod   = {{64{mul_sa & op1_q[63]}}, op1_q} * {{64{mul_sb & op2_q[63]}}, op2_q};

    // Divisors are sanitised so the dividers never see x/0 or MIN/-1; those cases are
    // resolved by the architectural results selected below.
    assign div_zero = op2_q == 64'd0;
    assign div_ovf  = op1_q == MinNeg && op2_q == '1;
    assign udiv_b   = div_zero ? 64'd1 : op2_q;
    assign sdiv_b   = (div_zero || div_ovf) ? 64'd1 : op2_q;
    assign udiv     = op1_q / udiv_b;
    assign urem     = op1_q % udiv_b;
    assign sdiv     = 64'($signed(op1_q) / $signed(sdiv_b));
    assign srem     = 64'($signed(op1_q) % $signed(sdiv_b));

    always_comb begin
        alu_out = 64'd0;
        if (funct7_q == 7'b0000001) begin
            case (funct3_q)
                3'b000:                 alu_out = prod[63:0];
                3'b001, 3'b010, 3'b011: alu_out = prod[127:64];
                3'b100:                 alu_out = div_zero ? '1 : (div_ovf ? op1_q : sdiv);
                3'b101:                 alu_out = div_zero ? '1 : udiv;
                3'b110:                 alu_out = div_zero ? op1_q : (div_ovf ? 64'd0 : srem);
                default:                alu_out = div_zero ? op1_q : urem;
            endcase
        end else begin
            case (funct3_q)
                3'b000:  alu_out = funct7_q[5] ? op1_q - op2_q : op1_q + op2_q;
                3'b001:  alu_out = op1_q << op2_q[5:0];
                3'b010:  alu_out = {63'd0, $signed(op1_q) < $signed(op2_q)};
                3'b011:  alu_out = {63'd0, op1_q < op2_q};
                3'b100:  alu_out = op1_q ^ op2_q;
                3'b101:  alu_out = funct7_q[5] ? 64'($signed(op1_q) >>> op2_q[5:0])
                                               : op1_q >> op2_q[5:0];
                3'b110:  alu_out = op1_q | op2_q;
                default: alu_out = op1_q & op2_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a randomized scoreboard run.
module tb_ex_stage;
    localparam int unsigned LAT = 4;

    localparam int OpAdd = 0, OpSub = 1, OpXor = 2, OpOr = 3, OpAnd = 4, OpSll = 5;
    localparam int OpSrl = 6, OpSltu = 7, OpMul = 8, OpDivu = 9, OpRemu = 10, OpDiv = 11;

    logic [2:0] f3_tab [12] = '{3'd0, 3'd0, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd3,
                                3'd0, 3'd5, 3'd7, 3'd4};
    logic [6:0] f7_tab [12] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                7'h01, 7'h01, 7'h01, 7'h01};

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [63:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
    logic        in_use_imm, in_use_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;
    exp_t sb[$];

    ex_stage #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    function automatic logic [63:0] model(input int op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [5:0] sh;
        sh = b[5:0];
        case (op)
            OpAdd:  return a + b;
            OpSub:  return a - b;
            OpXor:  return a ^ b;
            OpOr:   return a | b;
            OpAnd:  return a & b;
            OpSll:  return a << sh;
            OpSrl:  return a >> sh;
            OpSltu: return (a < b) ? 64'd1 : 64'd0;
            OpMul:  return a * b;
            OpDivu: return (b == 0) ? '1 : a / b;
            OpRemu: return (b == 0) ? a : a % b;
            default: begin
                if (b == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                return 64'($signed(a) / $signed(b));
            end
        endcase
    endfunction

    function automatic bit is_m(input int op);
        return op >= OpMul;
    endfunction

    task automatic drive(input logic v, input int op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        in_valid = v; in_funct3 = f3_tab[op]; in_funct7 = f7_tab[op];
        in_rs1_val = a; in_rs2_val = b; in_imm = 64'd0; in_pc = 64'd0;
        in_use_imm = 1'b0; in_use_pc = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = rd;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, OpAdd, 64'd0, 64'd0, 5'd0);
        #2;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_result !== 64'd0) $display("FAIL reset_result got %h want 0", out_result); else n_pass++;
        n_checks++; if (out_rd !== 5'd0) $display("FAIL reset_rd got %0d want 0", out_rd); else n_pass++;
        #10 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_add_back_to_back;
        next_cycle();
        drive(1'b1, OpAdd, 64'd5, 64'd7, 5'd1);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL add_accept got %b want 1", in_ready); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i < 5) drive(1'b1, OpSub, 64'(100 + i), 64'(i * 3), 5'(i + 2));
            else in_valid = 1'b0;
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
            if (i == 0) begin
                n_checks++; if (out_result !== 64'd12) $display("FAIL add_result got %0d want 12", out_result); else n_pass++;
            end else begin
                n_checks++;
                if (out_result !== 64'(100 + i - 1 - (i - 1) * 3) || out_rd !== 5'(i + 1))
                    $display("FAIL b2b_result[%0d] got %0d/rd%0d want %0d/rd%0d", i, out_result, out_rd, 100 + i - 1 - (i - 1) * 3, i + 1);
                else n_pass++;
            end
            if (i < 5) begin
                n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); else n_pass++;
            end
        end
        next_cycle();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_mul;
        next_cycle();
        drive(1'b1, OpMul, 64'd6, 64'd7, 5'd9);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            drive(1'b1, OpAdd, 64'd1, 64'd2, 5'd10);
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL mul_busy[%0d] got ready=%b valid=%b want 0/0", c, in_ready, out_valid); else n_pass++;
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 64'd42 || out_rd !== 5'd9)
            $display("FAIL mul_result got v=%b %0d rd%0d want 1 42 rd9", out_valid, out_result, out_rd);
        else n_pass++;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 64'd3) $display("FAIL mul_follow got %0d want 3", out_result); else n_pass++;
        next_cycle();
    endtask

    task automatic test_backpressure;
        next_cycle();
        drive(1'b1, OpXor, 64'hF0, 64'hDEAD, 5'd7);
        in_use_imm = 1'b1; in_imm = 64'h0F; out_ready = 1'b0;
        next_cycle();
        drive(1'b1, OpAdd, 64'd2, 64'd3, 5'd8);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== 64'hFF || out_rd !== 5'd7 || in_ready !== 1'b0)
                $display("FAIL bp_hold[%0d] got v=%b %h rd%0d ready=%b want 1 ff rd7 0", c, out_valid, out_result, out_rd, in_ready);
            else n_pass++;
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", in_ready); else n_pass++;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 64'd5 || out_rd !== 5'd8) $display("FAIL bp_next got %0d rd%0d want 5 rd8", out_result, out_rd); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_single got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush;
        next_cycle();
        drive(1'b1, OpDiv, 64'd100, 64'd7, 5'd5);
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        flush = 1'b1;
        drive(1'b1, OpAdd, 64'd9, 64'd9, 5'd6);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", in_ready); else n_pass++;
        for (int c = 3; c <= 7; c++) begin
            next_cycle();
            flush = 1'b0; in_valid = 1'b0;
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_quiet[%0d] got %b want 0", c, out_valid); else n_pass++;
        end
        next_cycle();
        drive(1'b1, OpAdd, 64'd1, 64'd1, 5'd1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 64'd2) $display("FAIL flush_after got v=%b %0d want 1 2", out_valid, out_result); else n_pass++;
        next_cycle();
    endtask

    task automatic test_forward;
        logic [63:0] want;
`ifdef EX_FWD_EN
        want = 64'd20;
`else
        want = 64'd0;
`endif
        next_cycle();
        drive(1'b1, OpAdd, 64'd0, 64'd0, 5'd3);
        in_use_imm = 1'b1; in_imm = 64'd10; out_ready = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_result !== 64'd10) $display("FAIL fwd_addi got %0d want 10", out_result); else n_pass++;
        next_cycle();
        out_ready = 1'b1;
        drive(1'b1, OpAdd, 64'd0, 64'd0, 5'd4);
        in_rs1 = 5'd3; in_rs2 = 5'd3;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_result !== want) $display("FAIL fwd_add got %0d want %0d", out_result, want); else n_pass++;
        next_cycle();
    endtask

    task automatic test_async_reset;
        next_cycle();
        drive(1'b1, OpMul, 64'd3, 64'd5, 5'd2);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_result !== 64'd0 || out_rd !== 5'd0)
            $display("FAIL areset_now got v=%b %0d rd%0d want 0 0 0", out_valid, out_result, out_rd);
        else n_pass++;
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL areset_ready got %b want 1", in_ready); else n_pass++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_ghost[%0d] got %b want 0", c, out_valid); else n_pass++;
        end
    endtask

    task automatic test_random;
        logic        exp_ov, exp_ir;
        logic [63:0] a, b;
        int          op;
        exp_t        e;
        sb.delete();
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            op = int'($urandom_range(0, 11));
            a = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom};
            b = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom};
            drive($urandom_range(0, 3) != 0, op, a, b, 5'($urandom_range(0, 7)));
            in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
            in_use_imm = $urandom_range(0, 3) == 0; in_imm = {$urandom, $urandom};
            in_use_pc = $urandom_range(0, 3) == 0; in_pc = {$urandom, $urandom};
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 24) == 0;
            @(negedge clk);
            exp_ov = sb.size() > 0 && c >= sb[0].due;
            exp_ir = !flush && (sb.size() == 0 || (exp_ov && out_ready));
            n_checks++; if (out_valid !== exp_ov) $display("FAIL rnd_valid[%0d] got %b want %b", c, out_valid, exp_ov); else n_pass++;
            n_checks++; if (in_ready !== exp_ir) $display("FAIL rnd_ready[%0d] got %b want %b", c, in_ready, exp_ir); else n_pass++;
            if (exp_ov) begin
                n_checks++;
                if (out_result !== sb[0].res || out_rd !== sb[0].rd)
                    $display("FAIL rnd_result[%0d] got %h rd%0d want %h rd%0d", c, out_result, out_rd, sb[0].res, sb[0].rd);
                else n_pass++;
            end
`ifdef EX_FWD_EN
            if (exp_ov && sb[0].rd != 0 && sb[0].rd == in_rs1) a = sb[0].res;
            if (exp_ov && sb[0].rd != 0 && sb[0].rd == in_rs2) b = sb[0].res;
`endif
            if (in_use_pc) a = in_pc;
            if (in_use_imm) b = in_imm;
            if (flush) begin
                sb.delete();
            end else begin
                if (exp_ov && out_ready) void'(sb.pop_front());
                if (in_valid && exp_ir) begin
                    e.res = model(op, a, b);
                    e.rd = in_rd;
                    e.due = c + (is_m(op) ? int'(LAT) : 1);
                    sb.push_back(e);
                end
            end
        end
        next_cycle();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add_back_to_back();
        test_mul();
        test_backpressure();
        test_flush();
        test_forward();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
